// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control
// Purpose  : Instruction register, decoder and control FSM feeding the CPU
//            datapath. Accepts one 16-bit instruction per valid/ready
//            handshake and steps it through the datapath strobes/selects.
// Options  : CTRL_RETIRE_CNT_EN - adds the 'retired' port and a RETIRE_W-bit
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic                write,
    output logic                loada,
    output logic                loadb,
    output logic                asel,
    output logic                bsel,
    output logic                loadc,
    output logic                loads,
    output logic [1:0]          vsel,
    output logic [2:0]          readnum,
    output logic [2:0]          writenum,
    output logic [1:0]          shift,
    output logic [1:0]          ALUop,
    output logic [15:0]         sximm8,
    output logic [15:0]         sximm5,
    output logic                halted,
    output logic                illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [RETIRE_W-1:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_EXEC      = 3'd5,
        S_WRITE_REG = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0] c_OPC_MOV  = 3'b110;
    localparam logic [2:0] c_OPC_ALU  = 3'b101;
    localparam logic [2:0] c_OPC_HALT = 3'b111;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    // Instruction fields
    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    // Opcode classification
    logic w_is_movimm;
    logic w_is_movreg;
    logic w_is_mvn;
    logic w_is_cmp;
    logic w_is_two_src;
    logic w_is_halt;

    assign w_is_movimm  = (w_opcode == c_OPC_MOV) && (w_op == 2'b10);
    assign w_is_movreg  = (w_opcode == c_OPC_MOV) && (w_op == 2'b00);
    assign w_is_mvn     = (w_opcode == c_OPC_ALU) && (w_op == 2'b11);
    assign w_is_cmp     = (w_opcode == c_OPC_ALU) && (w_op == 2'b01);
    // ADD, CMP and AND read both Rn and Rm
    assign w_is_two_src = (w_opcode == c_OPC_ALU) && (w_op != 2'b11);
    assign w_is_halt    = (w_opcode == c_OPC_HALT);

    // Immediates are pure functions of the held instruction word
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

    // State register and instruction register; IR only loads on a handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT) && instr_valid) begin
                r_ir <= instr;
            end
        end
    end

    // Next-state logic and Moore decode of all datapath controls
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        write       = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        vsel        = 2'b00;
        readnum     = 3'd0;
        writenum    = 3'd0;
        shift       = 2'b00;
        ALUop       = 2'b00;
        halted      = 1'b0;
        illegal     = 1'b0;

        case (r_state)
            S_WAIT: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_movimm) begin
                    w_next = S_WRITE_IMM;
                end else if (w_is_movreg || w_is_mvn) begin
                    w_next = S_GET_B;
                end else if (w_is_two_src) begin
                    w_next = S_GET_A;
                end else if (w_is_halt) begin
                    w_next = S_HALT;
                end else begin
                    illegal = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WRITE_IMM: begin
                write    = 1'b1;
                vsel     = 2'b01;
                writenum = w_rn;
                w_next   = S_WAIT;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = S_GET_B;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                shift = w_sh;
                bsel  = 1'b0;
                // MOV reg passes B through the ALU as an ADD with A forced to 0
                if (w_is_movreg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    asel  = 1'b0;
                    ALUop = w_op;
                end
                loadc  = !w_is_cmp;
                loads  = w_is_cmp;
                w_next = w_is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                write    = 1'b1;
                vsel     = 2'b11;
                writenum = w_rd;
                w_next   = S_WAIT;
            end
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic                r_retire_unused_guard;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_retire;

    // An instruction retires on the last cycle of its final state
    assign w_retire = (r_state == S_WRITE_IMM) || (r_state == S_WRITE_REG) ||
                      ((r_state == S_EXEC) && w_is_cmp);

    // Retired-instruction counter, wraps naturally at 2^RETIRE_W
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control
// Purpose  : Self-checking bench for cpu_control. Table of instructions with
//            their expected event timing, scoreboard queue of expectations,
//            and hand-written reset/halt sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control;

    localparam int c_RETIRE_W = 2;
    localparam int c_MAX_CYC  = 20;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        write, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;
    logic        halted, illegal;
`ifdef CTRL_RETIRE_CNT_EN
    logic [c_RETIRE_W-1:0] retired;
`endif

    cpu_control #(.RETIRE_W(c_RETIRE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .write       (write),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .loadc       (loadc),
        .loads       (loads),
        .vsel        (vsel),
        .readnum     (readnum),
        .writenum    (writenum),
        .shift       (shift),
        .ALUop       (ALUop),
        .sximm8      (sximm8),
        .sximm5      (sximm5),
        .halted      (halted),
        .illegal     (illegal)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected behaviour of one instruction: cycle numbers count from the
    // acceptance edge (cycle 1 = first cycle after it); 0 means "never".
    typedef struct {
        logic [15:0] instr;
        int          lat;
        int          wcyc;
        logic [2:0]  wn;
        logic [1:0]  vsel;
        int          acyc;
        logic [2:0]  rda;
        int          bcyc;
        logic [2:0]  rdb;
        int          ecyc;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  alu;
        logic [1:0]  sh;
        int          ill;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input int lat, input int wcyc,
                                input logic [2:0] wn, input logic [1:0] vs,
                                input int acyc, input logic [2:0] rda,
                                input int bcyc, input logic [2:0] rdb,
                                input int ecyc, input logic lc, input logic ls,
                                input logic as, input logic [1:0] alu,
                                input logic [1:0] sh, input int ill,
                                input logic [15:0] sx8, input logic [15:0] sx5);
        vec_t v;
        v.instr = i;   v.lat = lat;   v.wcyc = wcyc; v.wn = wn;   v.vsel = vs;
        v.acyc = acyc; v.rda = rda;   v.bcyc = bcyc; v.rdb = rdb; v.ecyc = ecyc;
        v.loadc = lc;  v.loads = ls;  v.asel = as;   v.alu = alu; v.sh = sh;
        v.ill = ill;   v.sx8 = sx8;   v.sx5 = sx5;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ready, hand over one word, push its expectation
    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (!instr_ready && n < c_MAX_CYC) begin
            tick();
            n++;
        end
        chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
        sb_q.push_back(v);
        instr       = v.instr;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    // Observe the instruction in flight until ready returns, then pop and compare
    task automatic observe();
        vec_t e;
        int   lat, wcnt, wcyc, acnt, acyc, bcnt, bcyc, ecnt, ecyc, lc_cnt, ls_cnt, ill_cnt;
        logic [2:0]  o_wn, o_rda, o_rdb;
        logic [1:0]  o_vsel, o_alu, o_sh;
        logic        o_asel;
        logic [15:0] o_sx8, o_sx5;
        lat = 0; wcnt = 0; wcyc = 0; acnt = 0; acyc = 0; bcnt = 0; bcyc = 0;
        ecnt = 0; ecyc = 0; lc_cnt = 0; ls_cnt = 0; ill_cnt = 0;
        o_wn = 0; o_rda = 0; o_rdb = 0; o_vsel = 0; o_alu = 0; o_sh = 0; o_asel = 0;
        o_sx8 = sximm8; o_sx5 = sximm5;
        for (int n = 1; n <= c_MAX_CYC; n++) begin
            if (write) begin wcnt++; wcyc = n; o_wn = writenum; o_vsel = vsel; end
            if (loada) begin acnt++; acyc = n; o_rda = readnum; end
            if (loadb) begin bcnt++; bcyc = n; o_rdb = readnum; end
            if (loadc || loads) begin
                ecnt++; ecyc = n; o_alu = ALUop; o_sh = shift; o_asel = asel;
            end
            if (loadc)   lc_cnt++;
            if (loads)   ls_cnt++;
            if (illegal) ill_cnt++;
            if (instr_ready) begin
                lat = n;
                break;
            end
            tick();
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        $display("instr 0x%04h: latency %0d", e.instr, lat);
        chk("latency",     lat,  e.lat);
        chk("sximm8",      {16'd0, o_sx8}, {16'd0, e.sx8});
        chk("sximm5",      {16'd0, o_sx5}, {16'd0, e.sx5});
        chk("write_count", wcnt, (e.wcyc != 0) ? 1 : 0);
        chk("write_cycle", wcyc, e.wcyc);
        chk("loada_count", acnt, (e.acyc != 0) ? 1 : 0);
        chk("loada_cycle", acyc, e.acyc);
        chk("loadb_count", bcnt, (e.bcyc != 0) ? 1 : 0);
        chk("loadb_cycle", bcyc, e.bcyc);
        chk("exec_count",  ecnt, (e.ecyc != 0) ? 1 : 0);
        chk("exec_cycle",  ecyc, e.ecyc);
        chk("loadc_count", lc_cnt, (e.ecyc != 0 && e.loadc) ? 1 : 0);
        chk("loads_count", ls_cnt, (e.ecyc != 0 && e.loads) ? 1 : 0);
        chk("illegal_count", ill_cnt, e.ill);
        if (e.wcyc != 0) begin
            chk("writenum", {29'd0, o_wn},   {29'd0, e.wn});
            chk("vsel",     {30'd0, o_vsel}, {30'd0, e.vsel});
        end
        if (e.acyc != 0) chk("readnum_a", {29'd0, o_rda}, {29'd0, e.rda});
        if (e.bcyc != 0) chk("readnum_b", {29'd0, o_rdb}, {29'd0, e.rdb});
        if (e.ecyc != 0) begin
            chk("ALUop", {30'd0, o_alu},  {30'd0, e.alu});
            chk("shift", {30'd0, o_sh},   {30'd0, e.sh});
            chk("asel",  {31'd0, o_asel}, {31'd0, e.asel});
        end
    endtask

    initial begin
        int bad;
        //             instr    lat wc wn vs  ac ra bc rb ec lc ls as alu sh ill sx8      sx5
        vecs[0]  = mk(16'hD007, 3, 2, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007, 16'h0007);
        vecs[1]  = mk(16'hD1FE, 3, 2, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE);
        vecs[2]  = mk(16'hA148, 6, 5, 2, 3,  2, 1, 3, 0, 4, 1, 0, 0, 0, 1, 0, 16'h0048, 16'h0008);
        vecs[3]  = mk(16'hA801, 5, 0, 0, 0,  2, 0, 3, 1, 4, 0, 1, 0, 1, 0, 0, 16'h0001, 16'h0001);
        vecs[4]  = mk(16'hC0E3, 5, 4, 7, 3,  0, 0, 2, 3, 3, 1, 0, 1, 0, 0, 0, 16'hFFE3, 16'h0003);
        vecs[5]  = mk(16'hB8B2, 5, 4, 5, 3,  0, 0, 2, 2, 3, 1, 0, 0, 3, 2, 0, 16'hFFB2, 16'hFFF2);
        vecs[6]  = mk(16'hB386, 6, 5, 4, 3,  2, 3, 3, 6, 4, 1, 0, 0, 2, 0, 0, 16'hFF86, 16'h0006);
        vecs[7]  = mk(16'h0000, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        vecs[8]  = mk(16'hC800, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        vecs[9]  = mk(16'h8000, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        vecs[10] = mk(16'hD800, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        vecs[11] = mk(16'hD0F0, 3, 2, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFF0, 16'hFFF0);

        reset = 1'b1; instr = 16'h0000; instr_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
        chk("rst_halted",  {31'd0, halted},      32'd0);
        chk("rst_illegal", {31'd0, illegal},     32'd0);
        chk("rst_strobes", {24'd0, write, loada, loadb, asel, bsel, loadc, loads, 1'b0}, 32'd0);
        chk("rst_sximm8",  {16'd0, sximm8},      32'd0);

        // Table-driven instructions
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i]);
            observe();
        end

        // Reset during GET_B of an ADD abandons it
        issue(vecs[2]);
        tick(); tick();                       // now in cycle 3 = GET_B
        chk("midrst_loadb", {31'd0, loadb}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            if (write || loadc || loads || !instr_ready) bad++;
            tick();
        end
        chk("midrst_no_strobes", bad, 0);
        void'(sb_q.pop_front());

        // Reset wins over a simultaneous handshake
        reset = 1'b1; instr = 16'hD007; instr_valid = 1'b1;
        tick();
        reset = 1'b0; instr_valid = 1'b0;
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            if (write || !instr_ready) bad++;
            tick();
        end
        chk("rst_vs_handshake", bad, 0);

`ifdef CTRL_RETIRE_CNT_EN
        // Counter wraps at 2^RETIRE_W: five retirements on a 2-bit counter
        reset = 1'b1; tick(); reset = 1'b0;
        chk("retired_reset", {30'd0, retired}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            issue(vecs[0]);
            observe();
        end
        chk("retired_wrap", {30'd0, retired}, 32'd1);
`endif

        // HALT holds off further instructions until reset
        instr = 16'hE000; instr_valid = 1'b1;
        tick();                               // accepted; DECODE
        tick();                               // HALT
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            if (!halted || instr_ready || illegal || write) bad++;
            tick();
        end
        chk("halt_held", bad, 0);
        chk("halt_halted", {31'd0, halted},      32'd1);
        chk("halt_ready",  {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        chk("halt_rst_halted", {31'd0, halted},      32'd0);
        chk("halt_rst_ready",  {31'd0, instr_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
